// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage fed by the execute ALU.
// Runs one load or store over a valid/ready data-memory port, holds busy
// until the access completes, and returns lane-aligned extended load data.
// Optional feature: define LSU_TIMEOUT_EN to abort REQ/WAIT after
// TIMEOUT_CYCLES cycles with bus_error=1.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic [2:0]  r_funct;
    logic [1:0]  r_off;
    logic [31:0] r_mem_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_load_data;
    logic        r_misaligned;
    logic        r_illegal;
    logic        r_bus_error;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_req_error;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;
    logic        w_timeout_hit;

    // Classify the incoming request: illegal funct wins over misalignment.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (is_store) begin
            w_illegal = funct[2] | (funct[1:0] == 2'b11);
        end else begin
            w_illegal = (funct[1:0] == 2'b11) | (funct == 3'b110);
        end
        case (funct[1:0])
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = (addr[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        w_req_error = w_illegal | w_misaligned;
    end

    // Replicate store data across lanes and build byte enables (none on loads).
    always_comb begin
        w_wdata = 32'h0;
        w_wstrb = 4'b0000;
        if (is_store) begin
            case (funct[1:0])
                2'b00: begin
                    w_wdata = {4{store_data[7:0]}};
                    w_wstrb = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    w_wdata = {2{store_data[15:0]}};
                    w_wstrb = 4'b0011 << addr[1:0];
                end
                default: begin
                    w_wdata = store_data;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Shift the addressed lane down and sign/zero-extend it.
    always_comb begin
        w_shifted = mem_rdata >> {r_off, 3'b000};
        case (r_funct)
            3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_ext = {24'h0, w_shifted[7:0]};
            3'b101:  w_load_ext = {16'h0, w_shifted[15:0]};
            default: w_load_ext = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_timeout_cnt;

    // Count cycles spent waiting on memory; cleared whenever not in REQ/WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timeout_cnt <= '0;
        end else if (r_state == ST_REQ || r_state == ST_WAIT) begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
        end else begin
            r_timeout_cnt <= '0;
        end
    end

    assign w_timeout_hit = (r_state == ST_REQ || r_state == ST_WAIT) &&
                           (r_timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign w_timeout_hit        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a memory handshake takes priority over a timeout in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = w_req_error ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                if (mem_ready)          w_next_state = r_we ? ST_DONE : ST_WAIT;
                else if (w_timeout_hit) w_next_state = ST_DONE;
            end
            ST_WAIT: begin
                if (mem_rvalid || w_timeout_hit) w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Latch the request in IDLE; capture load data or the abort result later.
    always_ff @(posedge clk) begin
        // NOTE: every output-visible register is reset so reset forces all outputs to 0.
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_funct      <= 3'b000;
            r_off        <= 2'b00;
            r_mem_addr   <= 32'h0;
            r_wdata      <= 32'h0;
            r_wstrb      <= 4'b0000;
            r_load_data  <= 32'h0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_we         <= is_store;
                        r_funct      <= funct;
                        r_off        <= addr[1:0];
                        r_mem_addr   <= {addr[31:2], 2'b00};
                        r_wdata      <= w_wdata;
                        r_wstrb      <= w_wstrb;
                        r_misaligned <= w_misaligned & ~w_illegal;
                        r_illegal    <= w_illegal;
                        r_bus_error  <= 1'b0;
                        if (w_req_error) r_load_data <= 32'h0;
                    end
                end
                ST_REQ: begin
                    if (!mem_ready && w_timeout_hit) begin
                        r_bus_error <= 1'b1;
                        r_load_data <= 32'h0;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_load_data <= w_load_ext;
                    end else if (w_timeout_hit) begin
                        r_bus_error <= 1'b1;
                        r_load_data <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign mem_req    = (r_state == ST_REQ);
    assign mem_we     = r_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_wstrb;
    assign load_data  = r_load_data;
    assign misaligned = r_misaligned;
    assign illegal    = r_illegal;
    assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. Cycle 0 is the cycle in which
// start is driven; all driving and sampling happens 1 ns after a rising edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        illegal;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct      (funct),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .illegal    (illegal),
        .bus_error  (bus_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start; returns in cycle 1.
    task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        start      = 1'b1;
        is_store   = st;
        funct      = f;
        addr       = a;
        store_data = d;
        tick();
        start      = 1'b0;
        is_store   = 1'b0;
        funct      = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
    endtask

    // Load with ready in cycle 1 and rvalid in cycle 2; returns in cycle 3 (DONE).
    task automatic load_txn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        issue(1'b0, f, a, 32'h0);
        mem_ready  = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    initial begin
        int cyc;
        rst_n      = 1'b0;
        start      = 1'b0;
        is_store   = 1'b0;
        funct      = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();

        // Reset state: every output 0.
        check("rst_busy",      {31'h0, busy},      32'h0);
        check("rst_done",      {31'h0, done},      32'h0);
        check("rst_mem_req",   {31'h0, mem_req},   32'h0);
        check("rst_load_data", load_data,          32'h0);
        check("rst_mem_addr",  mem_addr,           32'h0);
        check("rst_flags",     {29'h0, misaligned, illegal, bus_error}, 32'h0);
        rst_n = 1'b1;
        tick();

        // LW 0x100: mem_req at cycle 1, done at cycle 3.
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        check("lw_c1_mem_req",  {31'h0, mem_req}, 32'h1);
        check("lw_c1_busy",     {31'h0, busy},    32'h1);
        check("lw_c1_mem_addr", mem_addr,         32'h0000_0100);
        check("lw_c1_we_strb",  {27'h0, mem_we, mem_wstrb}, 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("lw_c2_mem_req",  {31'h0, mem_req}, 32'h0);
        check("lw_c2_done",     {31'h0, done},    32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("lw_c3_done",      {31'h0, done}, 32'h1);
        check("lw_c3_load_data", load_data,     32'hDEAD_BEEF);
        check("lw_c3_flags",     {29'h0, misaligned, illegal, bus_error}, 32'h0);
        start = 1'b1;                       // start during DONE must be ignored
        addr  = 32'h0000_0400;
        tick();
        start = 1'b0;
        addr  = 32'h0;
        check("lw_c4_done",      {31'h0, done}, 32'h0);
        check("lw_c4_busy",      {31'h0, busy}, 32'h0);
        check("lw_c4_held_data", load_data,     32'hDEAD_BEEF);
        tick();
        check("ign_start_busy",  {31'h0, busy}, 32'h0);

        // Sub-word loads with extension.
        load_txn(3'b000, 32'h0000_0103, 32'h8011_2233);
        check("lb_103",  load_data, 32'hFFFF_FF80);
        tick();
        load_txn(3'b100, 32'h0000_0103, 32'h8011_2233);
        check("lbu_103", load_data, 32'h0000_0080);
        tick();
        load_txn(3'b001, 32'h0000_0102, 32'h8011_2233);
        check("lh_102",  load_data, 32'hFFFF_8011);
        tick();
        load_txn(3'b101, 32'h0000_0102, 32'h8011_2233);
        check("lhu_102", load_data, 32'h0000_8011);
        tick();
        load_txn(3'b000, 32'h0000_0101, 32'h8011_2233);
        check("lb_101",  load_data, 32'h0000_0022);
        tick();

        // SH 0x202: done at cycle 2.
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
        check("sh_mem_req",   {31'h0, mem_req}, 32'h1);
        check("sh_mem_we",    {31'h0, mem_we},  32'h1);
        check("sh_mem_addr",  mem_addr,         32'h0000_0200);
        check("sh_mem_wdata", mem_wdata,        32'hABCD_ABCD);
        check("sh_mem_wstrb", {28'h0, mem_wstrb}, 32'h0000_000C);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("sh_c2_done",    {31'h0, done},    32'h1);
        check("sh_c2_mem_req", {31'h0, mem_req}, 32'h0);
        check("sh_held_data",  load_data,        32'h0000_0022);
        tick();

        // SB 0x201 and SW 0x204 lane placement.
        issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56EF);
        check("sb_mem_wdata", mem_wdata, 32'hEFEF_EFEF);
        check("sb_mem_wstrb", {28'h0, mem_wstrb}, 32'h0000_0002);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("sb_done", {31'h0, done}, 32'h1);
        tick();
        issue(1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D);
        check("sw_mem_addr",  mem_addr,  32'h0000_0204);
        check("sw_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        check("sw_mem_wstrb", {28'h0, mem_wstrb}, 32'h0000_000F);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();

        // Error completions: done at cycle 1, no memory request.
        issue(1'b0, 3'b010, 32'h0000_0101, 32'h0);
        check("mis_lw_done",    {31'h0, done},    32'h1);
        check("mis_lw_busy",    {31'h0, busy},    32'h1);
        check("mis_lw_mem_req", {31'h0, mem_req}, 32'h0);
        check("mis_lw_flags",   {29'h0, misaligned, illegal, bus_error}, 32'h4);
        check("mis_lw_data",    load_data,        32'h0);
        tick();
        issue(1'b0, 3'b001, 32'h0000_0103, 32'h0);
        check("mis_lh_flags", {29'h0, misaligned, illegal, bus_error}, 32'h4);
        tick();
        issue(1'b1, 3'b011, 32'h0000_0200, 32'h0);
        check("ill_st_done",    {31'h0, done},    32'h1);
        check("ill_st_mem_req", {31'h0, mem_req}, 32'h0);
        check("ill_st_flags",   {29'h0, misaligned, illegal, bus_error}, 32'h2);
        tick();
        issue(1'b0, 3'b110, 32'h0000_0101, 32'h0);   // illegal and misaligned
        check("ill_mis_flags", {29'h0, misaligned, illegal, bus_error}, 32'h2);
        tick();

        // Back-pressure: request stays stable, start pulses ignored.
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            addr  = 32'h0000_0990;
            check("stall_mem_req",  {31'h0, mem_req}, 32'h1);
            check("stall_mem_addr", mem_addr,         32'h0000_0300);
            check("stall_busy",     {31'h0, busy},    32'h1);
            tick();
        end
        start = 1'b0;
        addr  = 32'h0;
        check("stall_end_addr", mem_addr, 32'h0000_0300);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("wait_done", {31'h0, done}, 32'h0);
        tick();
        // Reset while in WAIT abandons the load.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("wrst_busy",     {31'h0, busy},    32'h0);
        check("wrst_done",     {31'h0, done},    32'h0);
        check("wrst_mem_req",  {31'h0, mem_req}, 32'h0);
        check("wrst_mem_addr", mem_addr,         32'h0);
        check("wrst_data",     load_data,        32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        check("wrst_no_done", {31'h0, done}, 32'h0);

        // Memory never ready.
        issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
`ifdef LSU_TIMEOUT_EN
        check("to_done_cycle", cyc,                 32'd17);
        check("to_bus_error",  {31'h0, bus_error},  32'h1);
        check("to_load_data",  load_data,           32'h0);
        check("to_mem_req",    {31'h0, mem_req},    32'h0);
        tick();
        check("to_idle", {31'h0, busy}, 32'h0);
`else
        check("nto_no_done",   {31'h0, done},      32'h0);
        check("nto_busy",      {31'h0, busy},      32'h1);
        check("nto_mem_req",   {31'h0, mem_req},   32'h1);
        check("nto_bus_error", {31'h0, bus_error}, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("nto_rst_busy", {31'h0, busy}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
